trdb_rst_seq: RTL and testbench
===============================

# trdb_rst_seq

Parametrised reset sequencer for the trace debugger subsystem. It releases `NUM_CH` active-low domain resets one after another, with a programmable per-channel delay, after a global hold period. It also re-runs the full sequence on a valid/ready request. It replaces the fixed, single-reset wait-and-release generation used so far with synthesizable, multi-channel, re-triggerable sequencing. It sits between the global reset source and the trace debugger, the capture logic and the interface domains.

## Interface
- `NUM_CH`, 4: number of sequenced reset channels (≥1).
- `CNT_W`, 8: width of each per-channel delay field and of the internal counter.
- `HOLD_CYCLES`, 16: cycles all channels stay asserted before channel 0 starts; 1 ≤ `HOLD_CYCLES` ≤ 2**`CNT_W`.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `test_mode_i`  in  1  scan bypass: every `ch_rst_no` bit equals `~rst_i` combinationally.
- `wait_i`  in  `NUM_CH*CNT_W`  delay for channel k in bits [k*CNT_W +: CNT_W].
- `req_valid_i`  in  1  restart request.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `ch_rst_no`  out  `NUM_CH`  sequenced resets, active-low, registered.
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  all channels released.

## Operation
- FSM states: HOLD, WAIT, DONE. Registers: state, `cnt` (`CNT_W` bits), `idx` (max(1,$clog2(NUM_CH)) bits), `ch_rst_no`, `done_o`.
- Reset values: state=HOLD, `cnt`=HOLD_CYCLES-1, `idx`=0, `ch_rst_no`=all 0, `done_o`=0. `busy_o`=1 and `req_ready_o`=0 during reset.
- HOLD:
  - `cnt`≠0: decrement.
  - `cnt`==0: go to WAIT, load `cnt`=wait_i[0], set `idx`=0.
- WAIT:
  - `cnt`≠0: decrement.
  - `cnt`==0: set `ch_rst_no[idx]`=1.
  - If `idx`==NUM_CH-1: go to DONE and set `done_o`=1 on the same edge.
  - Otherwise: `idx`++ and load `cnt`=wait_i[idx+1].
- DONE: hold. `req_ready_o`=1 (combinational, state==DONE).
  - Handshake edge (valid&ready): `ch_rst_no`=all 0, `done_o`=0, `cnt`=HOLD_CYCLES-1, go to HOLD.
- `busy_o` = (state≠DONE).
- `req_valid_i` outside DONE is not accepted. The requester holds valid until ready; the sequencer never queues requests.
- `wait_i` is sampled only at the load edge. Changes during a countdown do not affect the running channel.
- Delay 0 is legal: the channel releases on the edge after its load.
- Released channels never re-assert except through an accepted request or `rst_i`.
- `rst_i` mid-sequence asynchronously returns all registers to reset values immediately. The sequence restarts from HOLD after deassertion.
- `test_mode_i` overrides only `ch_rst_no`. The FSM, `done_o` and `busy_o` run normally.

## Timing
- Edge 0 is the first rising edge with `rst_i` low. HOLD covers edges 0..HOLD_CYCLES-1, and WAIT is entered at edge HOLD_CYCLES-1.
- Channel k deasserts wait_k+1 edges after channel k-1. Channel 0 deasserts wait_0+1 edges after HOLD exit.
- Total latency from edge 0 to `done_o`=1: HOLD_CYCLES-1 + Σ(wait_k+1) edges.
- Request to the first `ch_rst_no` assertion is 1 edge, the handshake edge itself.
- `done_o` and the last channel release are visible after the same edge.

## Structure
- The shared package `trdb_pkg` holds the typedef `rstseq_state_e` (HOLD, WAIT, DONE) and a constant for the `idx` width function.
- One sub-module: `trdb_rstseq_cnt`, a loadable `CNT_W` down-counter with `load_i`, `val_i`, `dec_i`, `zero_o`.
- The FSM and output registers stay in `trdb_rst_seq`.

## Test plan
- Power-up, NUM_CH=4, HOLD_CYCLES=2, waits {0,3,1,2} → channel releases after edges 2/6/8/11; `done_o` rises after edge 11; `busy_o` falls after edge 11.
- In DONE, pulse `req_valid_i` one cycle → `req_ready_o`=1 on that cycle; all `ch_rst_no`=0 after the handshake edge; the identical release pattern repeats, offset by the handshake edge+1.
- `req_valid_i` held high from edge 3 → not accepted until DONE; exactly one restart follows; `req_ready_o` stays 0 throughout the sequence.
- `rst_i` pulsed asynchronously mid-WAIT (after ch1 released) → `ch_rst_no`=0000 immediately, without a clock edge; the full sequence restarts from HOLD.
- Change wait_i[1] from 3 to 9 one cycle after its load → ch1 still releases after 3+1 edges.
- `test_mode_i`=1 with `rst_i` toggled → `ch_rst_no` = {4{~rst_i}} combinationally; `done_o` timing is unchanged versus test 1.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared types and helpers for the trace debugger reset sequencer.
package trdb_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } rstseq_state_e;

   // Channel index width; a single channel still needs one index bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int RSTSEQ_NUM_CH_DEF = 4;
   localparam int RSTSEQ_IDX_W_DEF  = idx_width(RSTSEQ_NUM_CH_DEF);

endpackage

// File: rtl/trdb_rst_seq_if.sv
// Request handshake, delay configuration and reset outputs of the reset sequencer.
interface trdb_rst_seq_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
);
   logic [NUM_CH*CNT_W-1:0] wait_i;
   logic                    req_valid_i;
   logic                    req_ready_o;
   logic [NUM_CH-1:0]       ch_rst_no;
   logic                    busy_o;
   logic                    done_o;

   modport slave (
      input  wait_i,
      input  req_valid_i,
      output req_ready_o,
      output ch_rst_no,
      output busy_o,
      output done_o
   );

   modport master (
      output wait_i,
      output req_valid_i,
      input  req_ready_o,
      input  ch_rst_no,
      input  busy_o,
      input  done_o
   );
endinterface

// File: rtl/trdb_rstseq_cnt.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module trdb_rstseq_cnt #(
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= RST_VAL;
      end else if (load_i) begin
         cnt_q <= val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/trdb_rst_seq.sv
// Multi-channel reset sequencer: global hold, then per-channel delayed release,
// re-runnable through a valid/ready request once the sequence has completed.
//
// state | meaning
// HOLD  | all channels asserted, counting the global hold period
// WAIT  | counting the delay of channel idx, releases it at terminal count
// DONE  | all channels released, restart request accepted here
module trdb_rst_seq
   import trdb_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 8,
   parameter int HOLD_CYCLES = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          test_mode_i,
   trdb_rst_seq_if.slave bus
);

   localparam int               IDX_W    = idx_width(NUM_CH);
   localparam int               ARR_N    = 2**IDX_W;
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

   rstseq_state_e     state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
   logic [NUM_CH-1:0] ch_q, ch_d;
   logic              done_q, done_d;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]  cnt_val;
   logic [CNT_W-1:0]  wait_arr [ARR_N];

   // Padded to a power of two so idx+1 on the last channel never indexes out of range.
   for (genvar k = 0; k < ARR_N; k++) begin : g_wait
      if (k < NUM_CH) begin : g_used
         assign wait_arr[k] = bus.wait_i[k*CNT_W +: CNT_W];
      end else begin : g_pad
         assign wait_arr[k] = '0;
      end
   end

   assign idx_inc = idx_q + 1'b1;

   trdb_rstseq_cnt #(
      .CNT_W   (CNT_W),
      .RST_VAL (HOLD_LD)
   ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (cnt_load),
      .val_i  (cnt_val),
      .dec_i  (cnt_dec),
      .zero_o (cnt_zero)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= HOLD;
         idx_q   <= '0;
         ch_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ch_q    <= ch_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ch_d     = ch_q;
      done_d   = done_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = HOLD_LD;
      case (state_q)
         HOLD: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else begin
               state_d  = WAIT;
               idx_d    = '0;
               cnt_load = 1'b1;
               cnt_val  = wait_arr[0];
            end
         end
         WAIT: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else begin
               ch_d[idx_q] = 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d    = idx_inc;
                  cnt_load = 1'b1;
                  cnt_val  = wait_arr[idx_inc];
               end
            end
         end
         DONE: begin
            if (bus.req_valid_i) begin
               state_d  = HOLD;
               ch_d     = '0;
               done_d   = 1'b0;
               cnt_load = 1'b1;
               cnt_val  = HOLD_LD;
            end
         end
         default: state_d = HOLD;
      endcase
   end

   // Scan bypass follows the raw reset so domains are controllable without clocks.
   assign bus.ch_rst_no   = test_mode_i ? {NUM_CH{~rst_i}} : ch_q;
   assign bus.done_o      = done_q;
   assign bus.busy_o      = (state_q != DONE);
   assign bus.req_ready_o = (state_q == DONE);

endmodule

// File: tb/tb_trdb_rst_seq.sv
// Directed bench for trdb_rst_seq with NUM_CH=4, HOLD_CYCLES=2, waits {0,3,1,2}.
module tb_trdb_rst_seq;

   logic clk_i;
   logic rst_i;
   logic test_mode_i;
   int   n_chk;
   int   n_pass;

   trdb_rst_seq_if #(.NUM_CH(4), .CNT_W(8)) bus ();

   trdb_rst_seq #(
      .NUM_CH      (4),
      .CNT_W       (8),
      .HOLD_CYCLES (2)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .test_mode_i (test_mode_i),
      .bus         (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Release pattern after edge e (edge 0 = first edge of HOLD): ch0/1/2/3 at 2/6/8/11.
   function automatic logic [3:0] exp_ch(input int e);
      logic [3:0] r;
      r[0] = (e >= 2);
      r[1] = (e >= 6);
      r[2] = (e >= 8);
      r[3] = (e >= 11);
      return r;
   endfunction

   task automatic check_edge(input string tn, input int e);
      check($sformatf("%s ch e%0d", tn, e), 32'(bus.ch_rst_no), 32'(exp_ch(e)));
      check($sformatf("%s done e%0d", tn, e), 32'(bus.done_o), 32'(e >= 11));
      check($sformatf("%s busy e%0d", tn, e), 32'(bus.busy_o), 32'(e < 11));
      check($sformatf("%s ready e%0d", tn, e), 32'(bus.req_ready_o), 32'(e >= 11));
   endtask

   task automatic run_seq(input string tn);
      for (int e = 0; e < 12; e++) begin
         tick();
         check_edge(tn, e);
      end
   endtask

   task automatic do_reset(input string tn);
      rst_i = 1'b1;
      #1;
      check({tn, " rst ch"}, 32'(bus.ch_rst_no), 32'h0);
      check({tn, " rst done"}, 32'(bus.done_o), 32'h0);
      check({tn, " rst busy"}, 32'(bus.busy_o), 32'h1);
      check({tn, " rst ready"}, 32'(bus.req_ready_o), 32'h0);
      @(posedge clk_i);
      #3;
      rst_i = 1'b0;
   endtask

   initial begin
      n_chk           = 0;
      n_pass          = 0;
      rst_i           = 1'b1;
      test_mode_i     = 1'b0;
      bus.wait_i      = {8'd2, 8'd1, 8'd3, 8'd0};
      bus.req_valid_i = 1'b0;

      // power-up sequence
      do_reset("t1");
      run_seq("t1");

      // single-cycle restart request in DONE
      bus.req_valid_i = 1'b1;
      #1;
      check("t2 ready before hs", 32'(bus.req_ready_o), 32'h1);
      tick();
      bus.req_valid_i = 1'b0;
      check("t2 ch after hs", 32'(bus.ch_rst_no), 32'h0);
      check("t2 done after hs", 32'(bus.done_o), 32'h0);
      check("t2 busy after hs", 32'(bus.busy_o), 32'h1);
      run_seq("t2");

      // request held from edge 3 is only accepted once DONE is reached
      do_reset("t3");
      for (int e = 0; e < 12; e++) begin
         tick();
         check_edge("t3", e);
         if (e == 2) bus.req_valid_i = 1'b1;
      end
      tick();
      bus.req_valid_i = 1'b0;
      check("t3 ch after hs", 32'(bus.ch_rst_no), 32'h0);
      check("t3 done after hs", 32'(bus.done_o), 32'h0);
      run_seq("t3r");
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t3 stay done %0d", i), 32'(bus.done_o), 32'h1);
         check($sformatf("t3 stay ch %0d", i), 32'(bus.ch_rst_no), 32'hF);
      end

      // asynchronous reset after ch1 release
      do_reset("t4");
      for (int e = 0; e < 8; e++) begin
         tick();
         check_edge("t4", e);
      end
      #2;
      rst_i = 1'b1;
      #1;
      check("t4 async ch", 32'(bus.ch_rst_no), 32'h0);
      check("t4 async done", 32'(bus.done_o), 32'h0);
      check("t4 async busy", 32'(bus.busy_o), 32'h1);
      #1;
      rst_i = 1'b0;
      run_seq("t4r");

      // wait_i[1] changed one cycle after its load does not alter ch1 timing
      do_reset("t5");
      for (int e = 0; e < 12; e++) begin
         tick();
         check_edge("t5", e);
         if (e == 3) bus.wait_i[15:8] = 8'd9;
      end
      bus.wait_i[15:8] = 8'd3;

      // scan bypass
      test_mode_i = 1'b1;
      do_reset("t6");
      #1;
      check("t6 bypass rel", 32'(bus.ch_rst_no), 32'hF);
      for (int e = 0; e < 12; e++) begin
         tick();
         check($sformatf("t6 ch e%0d", e), 32'(bus.ch_rst_no), 32'hF);
         check($sformatf("t6 done e%0d", e), 32'(bus.done_o), 32'(e >= 11));
      end
      rst_i = 1'b1;
      #1;
      check("t6 bypass asserted", 32'(bus.ch_rst_no), 32'h0);
      check("t6 rst done", 32'(bus.done_o), 32'h0);
      rst_i = 1'b0;
      #1;
      check("t6 bypass released", 32'(bus.ch_rst_no), 32'hF);
      test_mode_i = 1'b0;
      #1;
      check("t6 functional ch", 32'(bus.ch_rst_no), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
